// File: rtl/per_rr_arbiter_ot.sv
// per_rr_arbiter_ot
// Round-robin arbiter that serialises N_MASTER request ports onto one
// peripheral slave port. Once a master is presented to the slave it stays
// selected until the slave grants it. An outstanding counter limits how many
// accepted transactions may still be waiting for a response. Responses are
// routed back to the originating master by a one-hot ID.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   data_req_i/add/wen/wdata/be  per-master request and payload (packed, master 0 in LSBs)
//   data_gnt_o                 per-master grant (combinational from data_gnt_i)
//   data_r_valid_o             per-master response valid (ID masked by valid)
//   data_req_o, payload, ID    request presented to the slave
//   data_gnt_i                 slave accepts the presented request
//   data_r_valid_i, data_r_ID_i  slave response and one-hot target ID
//   outstanding_o              accepted-but-unanswered transaction count
//   err_o                      sticky protocol-error flag
module per_rr_arbiter_ot #(
  parameter int N_MASTER        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int ID_WIDTH        = N_MASTER,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_MASTER-1:0]                    data_req_i,
  input  logic [N_MASTER*ADDR_WIDTH-1:0]         data_add_i,
  input  logic [N_MASTER-1:0]                    data_wen_i,
  input  logic [N_MASTER*DATA_WIDTH-1:0]         data_wdata_i,
  input  logic [N_MASTER*BE_WIDTH-1:0]           data_be_i,
  output logic [N_MASTER-1:0]                    data_gnt_o,
  output logic [N_MASTER-1:0]                    data_r_valid_o,
  output logic                                   data_req_o,
  output logic [ADDR_WIDTH-1:0]                  data_add_o,
  output logic                                   data_wen_o,
  output logic [DATA_WIDTH-1:0]                  data_wdata_o,
  output logic [BE_WIDTH-1:0]                    data_be_o,
  output logic [ID_WIDTH-1:0]                    data_ID_o,
  input  logic                                   data_gnt_i,
  input  logic                                   data_r_valid_i,
  input  logic [ID_WIDTH-1:0]                    data_r_ID_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   err_o
);

  localparam int PTR_W = $clog2(N_MASTER);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(N_MASTER - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Explicit wrap so non-power-of-two master counts never reach index N_MASTER.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
    logic [PTR_W-1:0] res;
    if (idx == IDX_LAST) begin
      res = {PTR_W{1'b0}};
    end else begin
      res = idx + PTR_W'(1'b1);
    end
    return res;
  endfunction

  function automatic logic is_onehot(input logic [ID_WIDTH-1:0] v);
    return $onehot(v);
  endfunction

  state_t           state_r, state_n_s;
  logic [PTR_W-1:0] rr_ptr_r, rr_ptr_n_s;
  logic [PTR_W-1:0] lock_idx_r, lock_idx_n_s;
  logic [CNT_W-1:0] cnt_r, cnt_n_s;
  logic             err_r, err_n_s;

  logic [PTR_W-1:0] scan_idx_s;
  logic [PTR_W-1:0] win_idx_s;
  logic             win_found_s;
  logic [PTR_W-1:0] sel_idx_s;
  logic             sel_valid_s;
  logic             full_s;
  logic             req_s;
  logic             hs_s;
  logic             drop_err_s;
  logic             underflow_s;
  logic             bad_id_s;

  // Round-robin scan: first requester at or after rr_ptr, wrapping to 0.
  always_comb begin
    win_idx_s   = {PTR_W{1'b0}};
    win_found_s = 1'b0;
    scan_idx_s  = rr_ptr_r;
    for (int i = 0; i < N_MASTER; i++) begin
      if (!win_found_s && data_req_i[scan_idx_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = scan_idx_s;
      end else begin
        win_found_s = win_found_s;
      end
      scan_idx_s = wrap_inc(scan_idx_s);
    end
  end

  // Selection, slave-side request and handshake. The full check uses the
  // registered count so a same-cycle response cannot open a grant.
  always_comb begin
    if (state_r == LOCKED) begin
      sel_idx_s   = lock_idx_r;
      sel_valid_s = data_req_i[lock_idx_r];
    end else begin
      sel_idx_s   = win_idx_s;
      sel_valid_s = win_found_s;
    end
    full_s = (cnt_r == CNT_MAX);
    req_s  = sel_valid_s & ~full_s;
    hs_s   = req_s & data_gnt_i;
  end

  // Output muxing: payload forced to zero when nothing is presented.
  always_comb begin
    data_req_o     = req_s;
    data_add_o     = {ADDR_WIDTH{1'b0}};
    data_wen_o     = 1'b0;
    data_wdata_o   = {DATA_WIDTH{1'b0}};
    data_be_o      = {BE_WIDTH{1'b0}};
    data_ID_o      = {ID_WIDTH{1'b0}};
    data_gnt_o     = {N_MASTER{1'b0}};
    data_r_valid_o = data_r_ID_i & {ID_WIDTH{data_r_valid_i}};
    if (req_s) begin
      data_add_o   = data_add_i[int'(sel_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
      data_wen_o   = data_wen_i[sel_idx_s];
      data_wdata_o = data_wdata_i[int'(sel_idx_s)*DATA_WIDTH +: DATA_WIDTH];
      data_be_o    = data_be_i[int'(sel_idx_s)*BE_WIDTH +: BE_WIDTH];
    end else begin
      data_add_o   = {ADDR_WIDTH{1'b0}};
    end
    for (int i = 0; i < N_MASTER; i++) begin
      data_ID_o[i]  = req_s & (sel_idx_s == PTR_W'(i));
      data_gnt_o[i] = hs_s & (sel_idx_s == PTR_W'(i));
    end
  end

  // Next-state logic for FSM, pointer, outstanding count and error flag.
  always_comb begin
    state_n_s    = state_r;
    lock_idx_n_s = lock_idx_r;
    rr_ptr_n_s   = rr_ptr_r;
    cnt_n_s      = cnt_r;
    drop_err_s   = 1'b0;

    case (state_r)
      IDLE: begin
        if (req_s && !data_gnt_i) begin
          state_n_s    = LOCKED;
          lock_idx_n_s = win_idx_s;
        end else begin
          state_n_s = IDLE;
        end
      end
      LOCKED: begin
        // A locked master must keep requesting until it is granted.
        if (!data_req_i[lock_idx_r]) begin
          state_n_s  = IDLE;
          drop_err_s = 1'b1;
        end else if (hs_s) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = LOCKED;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase

    if (hs_s) begin
      rr_ptr_n_s = wrap_inc(sel_idx_s);
    end else begin
      rr_ptr_n_s = rr_ptr_r;
    end

    // A response in the same cycle as a handshake at zero count answers the
    // transaction being accepted, so it is not an underflow.
    underflow_s = data_r_valid_i & ~hs_s & (cnt_r == {CNT_W{1'b0}});
    bad_id_s    = data_r_valid_i & ~is_onehot(data_r_ID_i);

    case ({hs_s, data_r_valid_i})
      2'b10: cnt_n_s = cnt_r + CNT_W'(1'b1);
      2'b01: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          cnt_n_s = {CNT_W{1'b0}};
        end else begin
          cnt_n_s = cnt_r - CNT_W'(1'b1);
        end
      end
      default: cnt_n_s = cnt_r;
    endcase

    err_n_s = err_r | drop_err_s | underflow_s | bad_id_s;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      rr_ptr_r   <= {PTR_W{1'b0}};
      lock_idx_r <= {PTR_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      rr_ptr_r   <= rr_ptr_n_s;
      lock_idx_r <= lock_idx_n_s;
      cnt_r      <= cnt_n_s;
      err_r      <= err_n_s;
    end
  end

  assign outstanding_o = cnt_r;
  assign err_o         = err_r;

endmodule

// File: tb/tb_per_rr_arbiter_ot.sv
// Directed testbench for per_rr_arbiter_ot: a 4-master instance (a_*) and a
// 3-master instance (b_*) sharing clock and reset.
module tb_per_rr_arbiter_ot;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // 4-master instance
  logic [3:0]   a_req, a_wen, a_gnt_o, a_rvo, a_id_o, a_rid;
  logic [127:0] a_add, a_wdata;
  logic [15:0]  a_be;
  logic         a_req_o, a_wen_o, a_gnt_i, a_rvi, a_err;
  logic [31:0]  a_add_o, a_wdata_o;
  logic [3:0]   a_be_o;
  logic [1:0]   a_out;

  // 3-master instance
  logic [2:0]   b_req, b_wen, b_gnt_o, b_rvo, b_id_o, b_rid;
  logic [95:0]  b_add, b_wdata;
  logic [11:0]  b_be;
  logic         b_req_o, b_wen_o, b_gnt_i, b_rvi, b_err;
  logic [31:0]  b_add_o, b_wdata_o;
  logic [3:0]   b_be_o;
  logic [1:0]   b_out;

  per_rr_arbiter_ot #(.N_MASTER(4), .MAX_OUTSTANDING(2)) dut_a (
    .clk(clk), .rst(rst),
    .data_req_i(a_req), .data_add_i(a_add), .data_wen_i(a_wen),
    .data_wdata_i(a_wdata), .data_be_i(a_be),
    .data_gnt_o(a_gnt_o), .data_r_valid_o(a_rvo),
    .data_req_o(a_req_o), .data_add_o(a_add_o), .data_wen_o(a_wen_o),
    .data_wdata_o(a_wdata_o), .data_be_o(a_be_o), .data_ID_o(a_id_o),
    .data_gnt_i(a_gnt_i), .data_r_valid_i(a_rvi), .data_r_ID_i(a_rid),
    .outstanding_o(a_out), .err_o(a_err)
  );

  per_rr_arbiter_ot #(.N_MASTER(3), .MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .rst(rst),
    .data_req_i(b_req), .data_add_i(b_add), .data_wen_i(b_wen),
    .data_wdata_i(b_wdata), .data_be_i(b_be),
    .data_gnt_o(b_gnt_o), .data_r_valid_o(b_rvo),
    .data_req_o(b_req_o), .data_add_o(b_add_o), .data_wen_o(b_wen_o),
    .data_wdata_o(b_wdata_o), .data_be_o(b_be_o), .data_ID_o(b_id_o),
    .data_gnt_i(b_gnt_i), .data_r_valid_i(b_rvi), .data_r_ID_i(b_rid),
    .outstanding_o(b_out), .err_o(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_g;
    rst = 1'b1;
    a_req = 4'b0; a_wen = 4'b0101; a_gnt_i = 1'b0; a_rvi = 1'b0; a_rid = 4'b0;
    b_req = 3'b0; b_wen = 3'b010;  b_gnt_i = 1'b0; b_rvi = 1'b0; b_rid = 3'b0;
    a_be = 16'hFFFF; b_be = 12'hFFF;
    for (int m = 0; m < 4; m++) begin
      a_add[m*32 +: 32]   = 32'hA000_0000 + 32'(m);
      a_wdata[m*32 +: 32] = 32'hDA00_0000 + 32'(m);
    end
    for (int m = 0; m < 3; m++) begin
      b_add[m*32 +: 32]   = 32'hB000_0000 + 32'(m);
      b_wdata[m*32 +: 32] = 32'hDB00_0000 + 32'(m);
    end

    // Reset state
    tick();
    chk("rst_req_o", {31'b0, a_req_o}, 32'd0);
    chk("rst_gnt_o", {28'b0, a_gnt_o}, 32'd0);
    chk("rst_out",   {30'b0, a_out}, 32'd0);
    chk("rst_err",   {31'b0, a_err}, 32'd0);
    chk("rst_add_o", a_add_o, 32'd0);
    chk("rst_b_out", {30'b0, b_out}, 32'd0);
    rst = 1'b0;

    // N=3: pointer wraps 2 -> 0
    b_req = 3'b100; b_gnt_i = 1'b1; b_rvi = 1'b1; b_rid = 3'b001; #1;
    chk("b_gnt_m2", {29'b0, b_gnt_o}, 32'h4);
    chk("b_add_m2", b_add_o, 32'hB000_0002);
    tick(); b_req = 3'b101; #1;
    chk("b_gnt_wrap0", {29'b0, b_gnt_o}, 32'h1);
    tick(); #1;
    chk("b_gnt_m2b", {29'b0, b_gnt_o}, 32'h4);
    tick(); #1;
    chk("b_gnt_wrap0b", {29'b0, b_gnt_o}, 32'h1);
    tick(); b_req = 3'b0; b_gnt_i = 1'b0; b_rvi = 1'b0; #1;
    chk("b_out_zero", {30'b0, b_out}, 32'd0);
    chk("b_err_zero", {31'b0, b_err}, 32'd0);

    // N=4: all requests, gnt and response every cycle
    a_req = 4'hF; a_gnt_i = 1'b1; a_rvi = 1'b1; a_rid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_g = 4'b0001 << (i % 4);
      chk("rr_gnt", {28'b0, a_gnt_o}, {28'b0, exp_g});
      chk("rr_add", a_add_o, 32'hA000_0000 + 32'(i % 4));
      chk("rr_out", {30'b0, a_out}, 32'd0);
      chk("rr_rvalid", {28'b0, a_rvo}, 32'h1);
      tick();
    end
    a_req = 4'b0; a_gnt_i = 1'b0; a_rvi = 1'b0; #1;
    chk("rr_out_end", {30'b0, a_out}, 32'd0);

    // Lock on master 1 while master 0 also requests
    rst = 1'b1; tick(); rst = 1'b0;
    a_req = 4'b0010; #1;
    chk("lock_id_c1", {28'b0, a_id_o}, 32'h2);
    chk("lock_gnt_c1", {28'b0, a_gnt_o}, 32'h0);
    tick(); a_req = 4'b0011; #1;
    chk("lock_id_c2", {28'b0, a_id_o}, 32'h2);
    tick(); #1;
    chk("lock_id_c3", {28'b0, a_id_o}, 32'h2);
    chk("lock_req_c3", {31'b0, a_req_o}, 32'h1);
    tick(); a_gnt_i = 1'b1; #1;
    chk("lock_gnt", {28'b0, a_gnt_o}, 32'h2);
    tick(); a_gnt_i = 1'b0; #1;
    chk("lock_out1", {30'b0, a_out}, 32'd1);
    chk("idle_id_m0", {28'b0, a_id_o}, 32'h1);
    a_gnt_i = 1'b1; #1;
    chk("idle_gnt_m0", {28'b0, a_gnt_o}, 32'h1);

    // Full: no request presented, grant ignored
    tick(); #1;
    chk("full_out2", {30'b0, a_out}, 32'd2);
    chk("full_req_o", {31'b0, a_req_o}, 32'd0);
    chk("full_gnt_o", {28'b0, a_gnt_o}, 32'd0);
    a_rvi = 1'b1; a_rid = 4'b0001; #1;
    chk("full_rvalid", {28'b0, a_rvo}, 32'h1);
    chk("full_same_cyc", {31'b0, a_req_o}, 32'd0);
    tick(); a_rvi = 1'b0; #1;
    chk("resume_out1", {30'b0, a_out}, 32'd1);
    chk("resume_gnt", {28'b0, a_gnt_o}, 32'h2);
    tick(); a_req = 4'b0; a_gnt_i = 1'b0; #1;
    chk("resume_out2", {30'b0, a_out}, 32'd2);
    chk("resume_err", {31'b0, a_err}, 32'd0);

    // Drain, then underflow error
    a_rvi = 1'b1; a_rid = 4'b0001;
    tick();
    chk("drain_out1", {30'b0, a_out}, 32'd1);
    tick();
    chk("drain_out0", {30'b0, a_out}, 32'd0);
    chk("drain_err0", {31'b0, a_err}, 32'd0);
    tick(); a_rvi = 1'b0; #1;
    chk("uflow_err", {31'b0, a_err}, 32'd1);
    chk("uflow_out", {30'b0, a_out}, 32'd0);
    tick();
    chk("uflow_sticky", {31'b0, a_err}, 32'd1);

    // Reset while LOCKED with one in flight
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_clr_err", {31'b0, a_err}, 32'd0);
    a_req = 4'b0001; a_gnt_i = 1'b1; #1;
    chk("pre_gnt_m0", {28'b0, a_gnt_o}, 32'h1);
    tick(); a_req = 4'b0010; a_gnt_i = 1'b0; #1;
    chk("pre_lock_id", {28'b0, a_id_o}, 32'h2);
    tick(); #1;
    chk("pre_lock_out", {30'b0, a_out}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    a_req = 4'b0101; a_gnt_i = 1'b1; #1;
    chk("post_rst_out", {30'b0, a_out}, 32'd0);
    chk("post_rst_err", {31'b0, a_err}, 32'd0);
    chk("post_rst_id", {28'b0, a_id_o}, 32'h1);
    tick(); a_req = 4'b0; a_gnt_i = 1'b0; a_rvi = 1'b1; a_rid = 4'b0001;
    tick(); a_rvi = 1'b0; #1;
    chk("clean_out", {30'b0, a_out}, 32'd0);
    chk("clean_err", {31'b0, a_err}, 32'd0);

    // Locked master drops its request
    a_req = 4'b0100; #1;
    chk("drop_id", {28'b0, a_id_o}, 32'h4);
    tick(); a_req = 4'b0; #1;
    chk("drop_req_o", {31'b0, a_req_o}, 32'd0);
    tick();
    chk("drop_err", {31'b0, a_err}, 32'd1);
    chk("drop_out", {30'b0, a_out}, 32'd0);

    // Non-one-hot response ID is routed as-is and flags an error
    rst = 1'b1; tick(); rst = 1'b0;
    a_req = 4'b0001; a_gnt_i = 1'b1;
    tick(); a_req = 4'b0; a_gnt_i = 1'b0; a_rvi = 1'b1; a_rid = 4'b0011; #1;
    chk("badid_route", {28'b0, a_rvo}, 32'h3);
    tick(); a_rvi = 1'b0; #1;
    chk("badid_err", {31'b0, a_err}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
